seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Runtime-programmable serial pattern detector, the parametrised successor to the fixed 1011 detector.
//  Matches an up-to-MAX_LEN-bit pattern on a qualified serial bit stream, with overlapping or non-overlapping mode.
//  Emits a one-cycle match pulse and keeps a saturating match count.
//  Sits between the serial front-end and the control/status register block.
// PARAMETERS
//  MAX_LEN          8       longest supported pattern, >=2
//  LEN_W            4       width of cfg_len, $clog2(MAX_LEN+1)
//  CNT_W            16      match counter width
//  DEFAULT_PATTERN  8'h0B   pattern after reset, LSB-aligned (1011)
//  DEFAULT_LEN      4       pattern length after reset
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high
//  en           in   1       0: ignore inp_valid/inp_bit and hold all state
//  inp_valid    in   1       inp_bit is accepted this cycle when en and inp_valid are both 1
//  inp_bit      in   1       serial data bit
//  cfg_we       in   1       load cfg_pattern/cfg_len/cfg_overlap
//  cfg_pattern  in   MAX_LEN pattern bits; bit len-1 is the first bit in time, bit 0 the last
//  cfg_len      in   LEN_W   pattern length, legal range 1..MAX_LEN
//  cfg_overlap  in   1       1: overlapping matches allowed; 0: restart after each match
//  count_clr    in   1       synchronous clear of match_count
//  seq_seen     out  1       registered one-cycle match pulse
//  match_count  out  CNT_W   saturating number of matches
//  cfg_err      out  1       sticky; set by an illegal cfg_len write
// BEHAVIOUR
//  Reset values: seq_seen=0, match_count=0, cfg_err=0, hist=0, fill_cnt=0, state=FILL.
//   Config on reset: pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=1.
//  History register: hist is MAX_LEN bits; each accepted bit shifts in at hist[0].
//  Fill counter: fill_cnt counts accepted bits since the last restart and saturates at len.
//  Match condition on an accepted bit:
//   - fill_cnt+1 >= len, and
//   - {hist,inp_bit}[len-1:0] == pattern[len-1:0]. Bits at and above len are don't-care.
//  Latency: seq_seen goes high in the cycle after the accepted bit that completes the match, for exactly one cycle.
//   It is 0 in every other cycle, including cycles with no accepted bit.
//  FSM (typedef in package):
//   - FILL: fill_cnt < len-1. Moves to ARMED when an accepted bit makes fill_cnt reach len-1.
//   - ARMED: each accepted bit is compared. On a match:
//     - overlap=1: stay in ARMED; history is kept.
//     - overlap=0: fill_cnt<=0 and state<=FILL (hist need not be cleared).
//   - len=1: the block is permanently ARMED.
//  Config write (cfg_we=1):
//   - Legal cfg_len: latch all three cfg inputs, hist<=0, fill_cnt<=0, state<=FILL, cfg_err<=0.
//   - cfg_len==0 or cfg_len>MAX_LEN: keep the old config and state; cfg_err<=1.
//   - cfg_we has priority over an accepted bit in the same cycle; that bit is discarded and seq_seen stays 0 next cycle.
//  match_count:
//   - Increments on each match and saturates at all-ones; it never wraps.
//   - count_clr together with a match in the same cycle gives match_count=1 (no match is lost).
//   - count_clr alone gives 0.
//  en=0 freezes hist, fill_cnt, state and match_count. cfg_we and count_clr still act while en=0.
//  Reset mid-pattern: partial history is discarded and config returns to the defaults. Reset asserted alone never pulses seq_seen.
// STRUCTURE
//  Package seq_detect_pkg:
//   - state enum {FILL, ARMED}
//   - default MAX_LEN, CNT_W and DEFAULT_PATTERN constants
//  Sub-module seq_match_counter (CNT_W): inputs inc and clr, saturating, async reset.
//  All other logic lives in a single top.
// TESTING
//  1. Defaults, overlap, stream 1,0,1,1,0,1,1 (valid every cycle) -> seq_seen pulses after bits 4 and 7; match_count=2.
//  2. cfg 3'b101, len=3, overlap=0, stream 1,0,1,0,1 -> one pulse (after bit 3); with overlap=1 -> two pulses (bits 3, 5).
//  3. Write cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1 and the 1011 stream still matches; a legal write then clears cfg_err.
//  4. CNT_W=2, five matches -> match_count=3 held; count_clr with a match in the same cycle -> 1.
//  5. Stream 1,0,1, assert reset, then stream 1 -> no pulse; then 0,1,1 -> pulse. Also check inp_valid gaps and en=0 cycles inside 1011 -> match is still detected exactly once.
//  6. cfg_we in the same cycle as the final bit of 1011 -> no pulse, and hist is cleared.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and default constants for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int          MAX_LEN_DEF         = 8;
  localparam int          CNT_W_DEF           = 16;
  localparam logic [7:0]  DEFAULT_PATTERN_DEF = 8'h0B;
  localparam int          DEFAULT_LEN_DEF     = 4;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at one so that event is not lost.
module seq_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: compares the newest len bits of
// the accepted stream against a programmed pattern, with optional overlap.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN         = MAX_LEN_DEF,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W           = CNT_W_DEF,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEFAULT_PATTERN_DEF),
  parameter int                 DEFAULT_LEN     = DEFAULT_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               inp_valid,
  input  logic               inp_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam state_e RESET_STATE = (DEFAULT_LEN == 1) ? ARMED : FILL;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  state_e             state_q, state_d;
  logic               seen_q, seen_d;
  logic               err_q, err_d;

  logic               accept;
  logic               cfg_legal;
  logic               bits_eq;
  logic               match;
  logic [LEN_W-1:0]   len_m1;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;

  assign accept    = en && inp_valid;
  assign cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  assign len_m1    = len_q - LEN_W'(1);
  assign fill_inc  = fill_q + LEN_W'(1);

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Candidate window is the history with the incoming bit appended; the extra
  // top history bit is masked off because it can never be part of a pattern.
  assign bits_eq = ((({hist_q, inp_bit} ^ {1'b0, pat_q}) & {1'b0, len_mask}) == '0);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the if/case leaves one unassigned and no latch is inferred.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    err_d   = err_q;
    match   = 1'b0;

    if (cfg_we) begin
      if (cfg_legal) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = (cfg_len == LEN_W'(1)) ? ARMED : FILL;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (accept) begin
      hist_d = {hist_q[MAX_LEN-2:0], inp_bit};
      case (state_q)
        FILL: begin
          fill_d = fill_inc;
          if (fill_inc == len_m1) state_d = ARMED;
        end
        ARMED: begin
          match = bits_eq;
          if (fill_q != len_q) fill_d = fill_inc;
          // Non-overlapping mode restarts the fill; len=1 never leaves ARMED.
          if (match && !ovl_q) begin
            fill_d  = '0;
            state_d = (len_q == LEN_W'(1)) ? ARMED : FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end

    seen_d = match;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= LEN_W'(DEFAULT_LEN);
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= RESET_STATE;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (count_clr),
    .count (match_count)
  );

  assign seq_seen = seen_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench: directed scenarios then random traffic, both checked
// every cycle against a queue-based model of the detector's matching rules.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               inp_valid;
  logic               inp_bit;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;

  logic               seen, seen_s;
  logic [15:0]        cnt;
  logic [1:0]         cnt_s;
  logic               err, err_s;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulses       = 0;
  string cur_tag   = "reset";

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .inp_valid   (inp_valid),
    .inp_bit     (inp_bit),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .seq_seen    (seen),
    .match_count (cnt),
    .cfg_err     (err)
  );

  seq_detect_prog #(.CNT_W(2)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .inp_valid   (inp_valid),
    .inp_bit     (inp_bit),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .seq_seen    (seen_s),
    .match_count (cnt_s),
    .cfg_err     (err_s)
  );

  // Reference model: the accepted bits since the last restart, newest last.
  bit          q[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  bit          e_seen;
  int          e_cnt, e_cnt_s;
  bit          e_err;

  function automatic void model_reset();
    q.delete();
    m_pat   = 8'h0B;
    m_len   = 4;
    m_ovl   = 1'b1;
    e_seen  = 1'b0;
    e_cnt   = 0;
    e_cnt_s = 0;
    e_err   = 1'b0;
  endfunction

  function automatic void model_step();
    bit hit = 1'b0;
    if (cfg_we) begin
      if (cfg_len >= 1 && int'(cfg_len) <= MAX_LEN) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        q.delete();
        e_err = 1'b0;
      end else begin
        e_err = 1'b1;
      end
    end else if (en && inp_valid) begin
      q.push_back(inp_bit);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
      end
      if (hit && !m_ovl) q.delete();
    end
    if (count_clr) begin
      e_cnt   = hit ? 1 : 0;
      e_cnt_s = hit ? 1 : 0;
    end else if (hit) begin
      if (e_cnt < 65535) e_cnt++;
      if (e_cnt_s < 3)   e_cnt_s++;
    end
    e_seen = hit;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check({cur_tag, "/seq_seen"},      32'(seen),  32'(e_seen));
    check({cur_tag, "/match_count"},   32'(cnt),   32'(e_cnt));
    check({cur_tag, "/cfg_err"},       32'(err),   32'(e_err));
    check({cur_tag, "/seq_seen_c2"},   32'(seen_s), 32'(e_seen));
    check({cur_tag, "/match_count_c2"}, 32'(cnt_s), 32'(e_cnt_s));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    if (seen === 1'b1) pulses++;
    check_all();
  endtask

  task automatic bit_in(input bit b, input bit clr = 1'b0);
    en = 1'b1; inp_valid = 1'b1; inp_bit = b; cfg_we = 1'b0; count_clr = clr;
    step();
  endtask

  task automatic idle();
    en = 1'b1; inp_valid = 1'b0; inp_bit = 1'b0; cfg_we = 1'b0; count_clr = 1'b0;
    step();
  endtask

  task automatic frozen(input bit b);
    en = 1'b0; inp_valid = 1'b1; inp_bit = b; cfg_we = 1'b0; count_clr = 1'b0;
    step();
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                     input bit with_bit = 1'b0, input bit b = 1'b0);
    en = 1'b1; inp_valid = with_bit; inp_bit = b; count_clr = 1'b0;
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic stream(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; inp_valid = 1'b0; inp_bit = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    cur_tag = "t1_default_overlap";
    pulses = 0;
    stream(8'b0101_1011, 7);
    idle();
    check("t1_pulses", 32'(pulses), 32'd2);
    check("t1_count", 32'(cnt), 32'd2);

    cur_tag = "t2_nonoverlap";
    cfg(8'b101, 3, 1'b0);
    pulses = 0;
    stream(8'b10101, 5);
    idle();
    check("t2_nonoverlap_pulses", 32'(pulses), 32'd1);
    cur_tag = "t2_overlap";
    cfg(8'b101, 3, 1'b1);
    pulses = 0;
    stream(8'b10101, 5);
    idle();
    check("t2_overlap_pulses", 32'(pulses), 32'd2);

    cur_tag = "t3_cfg_err";
    do_reset();
    cfg(8'hFF, 0, 1'b0);
    check("t3_err_len0", 32'(err), 32'd1);
    cfg(8'hFF, 4'(MAX_LEN + 1), 1'b0);
    check("t3_err_len9", 32'(err), 32'd1);
    pulses = 0;
    stream(8'b1011, 4);
    idle();
    check("t3_old_cfg_pulses", 32'(pulses), 32'd1);
    cfg(8'h0B, 4, 1'b1);
    check("t3_err_cleared", 32'(err), 32'd0);

    cur_tag = "t4_saturate";
    cfg(8'h01, 1, 1'b1);
    repeat (5) bit_in(1'b1);
    idle();
    check("t4_sat_c2", 32'(cnt_s), 32'd3);
    bit_in(1'b1, 1'b1);
    check("t4_clr_with_match", 32'(cnt_s), 32'd1);
    bit_in(1'b0, 1'b1);
    check("t4_clr_alone", 32'(cnt_s), 32'd0);

    cur_tag = "t5_reset_mid";
    do_reset();
    pulses = 0;
    stream(8'b101, 3);
    do_reset();
    bit_in(1'b1);
    idle();
    check("t5_no_pulse_after_reset", 32'(pulses), 32'd0);
    stream(8'b011, 3);
    idle();
    check("t5_pulse_after_refill", 32'(pulses), 32'd1);
    cur_tag = "t5_gaps_freeze";
    do_reset();
    pulses = 0;
    bit_in(1'b1); idle(); bit_in(1'b0); frozen(1'b0); frozen(1'b1);
    bit_in(1'b1); idle(); frozen(1'b1); bit_in(1'b1); idle(); idle();
    check("t5_gap_pulses", 32'(pulses), 32'd1);

    cur_tag = "t6_cfg_priority";
    do_reset();
    pulses = 0;
    stream(8'b101, 3);
    cfg(8'h0B, 4, 1'b1, 1'b1, 1'b1);
    idle();
    bit_in(1'b1);
    idle();
    check("t6_no_pulse", 32'(pulses), 32'd0);

    cur_tag = "random";
    for (int n = 0; n < 600; n++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 4) begin
        cfg(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom));
      end else if (r == 4) begin
        do_reset();
      end else begin
        en          = ($urandom_range(0, 9) != 0);
        inp_valid   = ($urandom_range(0, 4) != 0);
        inp_bit     = 1'($urandom);
        count_clr   = ($urandom_range(0, 29) == 0);
        cfg_we      = 1'b0;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
